// File: rtl/fifo_ctrl_dp_ram_if.sv
// Push/pop and RAM-side bundle for fifo_ctrl_dp_ram.
//   slave  : the FIFO controller (drives flags, pop side and RAM write/read controls)
//   master : the surrounding producer/consumer/RAM environment
interface fifo_ctrl_dp_ram_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  push, push_data, pop, ram_rdata,
    output pop_data, pop_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
  );

  modport master (
    output push, push_data, pop, ram_rdata,
    input  pop_data, pop_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
  );
endinterface

// File: rtl/fifo_ctrl_dp_ram.sv
// Synchronous FIFO controller for an external simple dual-port RAM with a
// 1-cycle registered read. Owns the pointers, occupancy and status flags.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_ctrl_dp_ram_if.slave (push/pop handshake, flags, RAM controls)
module fifo_ctrl_dp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_ctrl_dp_ram_if.slave bus
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      count_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  pop_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  // Status decode from registered pointers only; wrap bit distinguishes full from empty.
  assign count_c = wr_ptr - rd_ptr;
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // Accept decisions use start-of-cycle flags.
  assign wr_acc = bus.push & ~full_c;
  assign rd_acc = bus.pop  & ~empty_c;

  // RAM side: read address always tracks rd_ptr so ram_re is only a hint.
  assign wdata_c       = bus.push_data;
  assign bus.ram_we    = wr_acc;
  assign bus.ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_wdata = wdata_c;
  assign bus.ram_re    = rd_acc;
  assign bus.ram_raddr = rd_ptr[ADDR_WIDTH-1:0];

  // Pop data passes straight through from the RAM's registered output.
  assign rdata_c      = bus.ram_rdata;
  assign bus.pop_data = rdata_c;

  assign bus.pop_valid    = pop_valid_q;
  assign bus.count        = count_c;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_c >= PTR_W'(AF_LEVEL));
  assign bus.almost_empty = (count_c <= PTR_W'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Pointer, pop-valid and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      pop_valid_q <= rd_acc;
      if (bus.push && full_c)  overflow_q  <= 1'b1;
      if (bus.pop  && empty_c) underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_dp_ram.sv
// Self-checking bench for fifo_ctrl_dp_ram: behavioural RAM, occupancy model
// and a data scoreboard queue filled on accepted pushes, drained on pop_valid.
module tb_fifo_ctrl_dp_ram;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_dp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ctrl_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Simple dual-port RAM, registered read that ignores ram_re.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];
  logic [AW:0] m_wr = '0;
  logic [AW:0] m_rd = '0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("rst_almost_full", 32'(bus.almost_full), 32'd0);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
  endtask

  // One clock cycle of stimulus; called at posedge+1.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
    logic [AW:0] cnt;
    bit wacc, racc;
    bus.push = p; bus.push_data = d; bus.pop = q;
    #1;
    cnt  = m_wr - m_rd;
    wacc = p && (cnt != 5'(DEPTH));
    racc = q && (cnt != 5'd0);
    chk("count", 32'(bus.count), 32'(cnt));
    chk("full", 32'(bus.full), 32'(cnt == 5'(DEPTH)));
    chk("empty", 32'(bus.empty), 32'(cnt == 5'd0));
    chk("almost_full", 32'(bus.almost_full), 32'(cnt >= 5'd14));
    chk("almost_empty", 32'(bus.almost_empty), 32'(cnt <= 5'd2));
    chk("ram_we", 32'(bus.ram_we), 32'(wacc));
    chk("ram_re", 32'(bus.ram_re), 32'(racc));
    chk("ram_waddr", 32'(bus.ram_waddr), 32'(m_wr[AW-1:0]));
    chk("ram_raddr", 32'(bus.ram_raddr), 32'(m_rd[AW-1:0]));
    if (wacc) chk("ram_wdata", 32'(bus.ram_wdata), 32'(d));
    @(posedge clk);
    #1;
    if (p && !wacc) m_ovf = 1'b1;
    if (q && !racc) m_unf = 1'b1;
    if (wacc) begin sb.push_back(d); m_wr = m_wr + 5'd1; end
    if (racc) m_rd = m_rd + 5'd1;
    chk("pop_valid", 32'(bus.pop_valid), 32'(racc));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
    if (racc) begin
      if (sb.size() == 0) chk("sb_underrun", 32'(sb.size()), 32'd1);
      else chk("pop_data", 32'(bus.pop_data), 32'(sb.pop_front()));
    end
    bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;
    // 1. reset then idle
    #1;
    chk_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // 2. fill to full, then a rejected push
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    chk("full_after_fill", 32'(bus.full), 32'd1);
    chk("count_after_fill", 32'(bus.count), 32'd16);

    // 3. drain in order
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("empty_after_drain", 32'(bus.empty), 32'd1);

    // 4. pop on empty
    step(1'b0, 8'h00, 1'b1);
    chk("underflow_set", 32'(bus.underflow), 32'd1);

    // 5. steady state at 8 with push+pop every cycle
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1);
      chk("steady_count", 32'(bus.count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    // 6. full with push+pop, then async reset mid-stream
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    chk("full_pushpop_count", 32'(bus.count), 32'd15);
    chk("full_pushpop_pv", 32'(bus.pop_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
